sample_decimator: RTL and testbench

Upstream feeder for the bitcrusher effect stage. Takes raw 12-bit ADC samples arriving on a valid strobe, averages each group of 2^LOG2_RATIO samples (boxcar decimation), and hands each average downstream with a one-cycle `start` pulse. It waits for the downstream `done` before issuing the next sample. A one-entry hold register absorbs jitter, and a sticky flag reports dropped averages.

---
 rtl/audio_pkg.sv | 14 +
 rtl/sample_accumulator.sv | 57 +++++
 rtl/sample_decimator.sv | 86 ++++++++
 tb/tb_sample_decimator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and FSM state encoding for the audio front-end blocks.
//   SAMPLE_W : default ADC sample width in bits
//   state_t  : issue FSM states (IDLE, ISSUE, WAIT_DONE)
package audio_pkg;

    localparam int SAMPLE_W = 12;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sample_accumulator.sv
// sample_accumulator: boxcar sum of 2^LOG2_RATIO samples, emits one average per group.
//   clock, reset (async, active-low)
//   adc_valid, adc_sample : incoming sample strobe and data
//   avg_valid, avg        : one-cycle average strobe (cycle after the group's last sample)
// Optional macro SAMPLE_ROUND_EN: round half up instead of truncating.
module sample_accumulator #(
    parameter int LOG2_RATIO = 2,
    parameter int SAMPLE_W   = audio_pkg::SAMPLE_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] adc_sample,
    output logic                avg_valid,
    output logic [SAMPLE_W-1:0] avg
);

    // One guard bit above the full group sum keeps the rounding add from overflowing.
    localparam int ACC_W = SAMPLE_W + LOG2_RATIO + 1;
    localparam int CNT_W = LOG2_RATIO + 1;
`ifdef SAMPLE_ROUND_EN
    localparam int RND = (1 << LOG2_RATIO) >> 1;
`else
    localparam int RND = 0;
`endif

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] count;
    logic             last;

    // The group's last sample is folded in combinationally so it lands in its own sum.
    assign sum  = acc + ACC_W'(adc_sample);
    assign last = count == CNT_W'((1 << LOG2_RATIO) - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            count     <= '0;
            avg_valid <= 1'b0;
            avg       <= '0;
        end else begin
            avg_valid <= adc_valid && last;
            if (adc_valid) begin
                if (last) begin
                    acc   <= '0;
                    count <= '0;
                    avg   <= SAMPLE_W'((sum + ACC_W'(RND)) >> LOG2_RATIO);
                end else begin
                    acc   <= sum;
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sample_decimator.sv
// sample_decimator: decimates ADC samples by 2^LOG2_RATIO and hands averages downstream
// with a start/done handshake, a one-entry hold register and a sticky overrun flag.
//   clock, reset (async, active-low)
//   adc_valid, adc_sample : incoming samples
//   crush_done            : downstream finished (honoured only in WAIT_DONE)
//   clear_overrun         : synchronous clear of overrun (a new overrun wins)
//   start                 : one-cycle pulse, sample_out valid from this cycle
//   sample_out            : averaged sample, stable until the next start
//   busy                  : high in ISSUE and WAIT_DONE
//   overrun               : sticky, set when an average is dropped
// Optional macro SAMPLE_ROUND_EN (passed to the accumulator): round half up.
module sample_decimator #(
    parameter int LOG2_RATIO = 2,
    parameter int SAMPLE_W   = audio_pkg::SAMPLE_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] adc_sample,
    input  logic                crush_done,
    input  logic                clear_overrun,
    output logic                start,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                busy,
    output logic                overrun
);

    import audio_pkg::*;

    state_t              state;
    logic                avg_valid;
    logic [SAMPLE_W-1:0] avg;
    logic [SAMPLE_W-1:0] hold;
    logic                hold_full;
    logic                drop;

    sample_accumulator #(
        .LOG2_RATIO(LOG2_RATIO),
        .SAMPLE_W  (SAMPLE_W)
    ) u_acc (
        .clock     (clock),
        .reset     (reset),
        .adc_valid (adc_valid),
        .adc_sample(adc_sample),
        .avg_valid (avg_valid),
        .avg       (avg)
    );

    assign start = state == ISSUE;
    assign busy  = state != IDLE;
    // A full hold keeps the older average; the newcomer is discarded.
    assign drop  = busy && avg_valid && hold_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sample_out <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A fresh average takes priority over the held one.
                    if (avg_valid) begin
                        sample_out <= avg;
                        state      <= ISSUE;
                    end else if (hold_full) begin
                        sample_out <= hold;
                        hold_full  <= 1'b0;
                        state      <= ISSUE;
                    end
                end
                ISSUE:     state <= WAIT_DONE;
                WAIT_DONE: if (crush_done) state <= IDLE;
                default:   state <= IDLE;
            endcase
            if (busy && avg_valid && !hold_full) begin
                hold      <= avg;
                hold_full <= 1'b1;
            end
            overrun <= drop || (overrun && !clear_overrun);
        end
    end

endmodule

// File: tb/tb_sample_decimator.sv
// tb_sample_decimator: scoreboard bench for sample_decimator (LOG2_RATIO=2 and 0 instances).
module tb_sample_decimator;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        adc_valid = 1'b0;
    logic [11:0] adc_sample = '0;
    logic        crush_done = 1'b0;
    logic        clear_overrun = 1'b0;
    logic        start, busy, overrun;
    logic [11:0] sample_out;

    logic        v0 = 1'b0;
    logic [11:0] s0 = '0;
    logic        start0, busy0, overrun0;
    logic [11:0] sample_out0;

    int          pass_cnt = 0;
    int          total = 0;
    logic [11:0] exp_q[$];

    always #5 clock = ~clock;

    sample_decimator #(.LOG2_RATIO(2), .SAMPLE_W(12)) dut (
        .clock(clock), .reset(reset), .adc_valid(adc_valid), .adc_sample(adc_sample),
        .crush_done(crush_done), .clear_overrun(clear_overrun), .start(start),
        .sample_out(sample_out), .busy(busy), .overrun(overrun)
    );

    sample_decimator #(.LOG2_RATIO(0), .SAMPLE_W(12)) dut0 (
        .clock(clock), .reset(reset), .adc_valid(v0), .adc_sample(s0),
        .crush_done(1'b1), .clear_overrun(1'b0), .start(start0),
        .sample_out(sample_out0), .busy(busy0), .overrun(overrun0)
    );

    function automatic logic [11:0] avg4(input int sum);
`ifdef SAMPLE_ROUND_EN
        return 12'((sum + 2) >> 2);
`else
        return 12'(sum >> 2);
`endif
    endfunction

    // Scoreboard: every start must deliver the oldest expected average.
    always @(negedge clock) begin
        if (reset && start) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_start sample_out=%0d expected no start", sample_out);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if (sample_out !== e)
                    $display("FAIL scoreboard sample_out=%0d expected %0d", sample_out, e);
                else
                    pass_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic strobe(input int s);
        adc_valid  = 1'b1;
        adc_sample = 12'(s);
        @(negedge clock);
        adc_valid  = 1'b0;
    endtask

    // Returns at the negedge right after the group's last strobe was sampled.
    task automatic group(input int a, input int b, input int c, input int d, input bit deliver);
        strobe(a);
        strobe(b);
        strobe(c);
        strobe(d);
        if (deliver) exp_q.push_back(avg4(a + b + c + d));
    endtask

    task automatic done_pulse();
        crush_done = 1'b1;
        @(negedge clock);
        crush_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        total++; if (start !== 1'b0) $display("FAIL reset_start got=%b exp=0", start); else pass_cnt++;
        total++; if (sample_out !== 12'd0) $display("FAIL reset_sample_out got=%0d exp=0", sample_out); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", overrun); else pass_cnt++;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_truncation();
        group(100, 101, 102, 103, 1);
        total++; if (start !== 1'b0) $display("FAIL trunc_early_start got=%b exp=0", start); else pass_cnt++;
        @(negedge clock);
        total++; if (start !== 1'b1) $display("FAIL trunc_start_t2 got=%b exp=1", start); else pass_cnt++;
        total++; if (sample_out !== avg4(406)) $display("FAIL trunc_value got=%0d exp=%0d", sample_out, avg4(406)); else pass_cnt++;
        @(negedge clock);
        done_pulse();
        total++; if (busy !== 1'b0) $display("FAIL trunc_idle got busy=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_max();
        group(4095, 4095, 4095, 4095, 1);
        @(negedge clock);
        total++; if (sample_out !== 12'd4095) $display("FAIL max_value got=%0d exp=4095", sample_out); else pass_cnt++;
        @(negedge clock);
        done_pulse();
    endtask

    task automatic test_handshake();
        group(300, 301, 302, 303, 1);
        crush_done = 1'b1;
        @(negedge clock);
        total++; if (start !== 1'b1) $display("FAIL hs_start got=%b exp=1", start); else pass_cnt++;
        @(negedge clock);
        crush_done = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL hs_done_in_issue got busy=%b exp=1", busy); else pass_cnt++;
        repeat (4) @(negedge clock);
        total++; if (busy !== 1'b1) $display("FAIL hs_wait got busy=%b exp=1", busy); else pass_cnt++;
        done_pulse();
        total++; if (busy !== 1'b0) $display("FAIL hs_done_idle got busy=%b exp=0", busy); else pass_cnt++;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_backpressure();
        group(10, 20, 30, 40, 1);
        group(1, 2, 3, 5, 1);
        group(500, 500, 500, 500, 0);
        @(negedge clock);
        total++; if (overrun !== 1'b1) $display("FAIL bp_overrun got=%b exp=1", overrun); else pass_cnt++;
        total++; if (busy !== 1'b1) $display("FAIL bp_busy got=%b exp=1", busy); else pass_cnt++;
        done_pulse();
        total++; if (start !== 1'b0 || busy !== 1'b0) $display("FAIL bp_idle got start=%b busy=%b exp 0 0", start, busy); else pass_cnt++;
        @(negedge clock);
        total++; if (start !== 1'b1) $display("FAIL bp_hold_start got=%b exp=1", start); else pass_cnt++;
        @(negedge clock);
        done_pulse();
        total++; if (overrun !== 1'b1) $display("FAIL bp_sticky got=%b exp=1", overrun); else pass_cnt++;
        clear_overrun = 1'b1;
        @(negedge clock);
        clear_overrun = 1'b0;
        total++; if (overrun !== 1'b0) $display("FAIL bp_clear got=%b exp=0", overrun); else pass_cnt++;
        repeat (6) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        group(50, 50, 50, 50, 1);
        group(60, 60, 60, 60, 0);
        strobe(7);
        strobe(8);
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++; if (start !== 1'b0 || busy !== 1'b0 || sample_out !== 12'd0 || overrun !== 1'b0)
            $display("FAIL mid_reset got start=%b busy=%b sample_out=%0d overrun=%b exp all 0", start, busy, sample_out, overrun);
        else pass_cnt++;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        group(200, 200, 200, 200, 1);
        @(negedge clock);
        total++; if (start !== 1'b1 || sample_out !== 12'd200)
            $display("FAIL mid_reset_fresh got start=%b sample_out=%0d exp 1 200", start, sample_out);
        else pass_cnt++;
        @(negedge clock);
        done_pulse();
        repeat (8) @(negedge clock);
        total++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_passthrough();
        int last_k = -1;
        int n = 0;
        logic [11:0] hist[$];
        for (int k = 0; k < 30; k++) begin
            if (start0) begin
                total++;
                if (hist.size() < 2 || sample_out0 !== hist[hist.size()-2])
                    $display("FAIL pt_value k=%0d got=%0d exp=%0d", k, sample_out0, hist.size() < 2 ? 0 : hist[hist.size()-2]);
                else pass_cnt++;
                total++;
                if (last_k < 0 ? (k != 2) : (k - last_k != 3))
                    $display("FAIL pt_spacing k=%0d got_prev=%0d exp spacing 3 (first at 2)", k, last_k);
                else pass_cnt++;
                last_k = k;
                n++;
            end
            v0 = 1'b1;
            s0 = 12'(k * 7 + 1);
            hist.push_back(s0);
            @(negedge clock);
        end
        v0 = 1'b0;
        total++; if (n != 10) $display("FAIL pt_count got=%0d exp=10", n); else pass_cnt++;
        total++; if (overrun0 !== 1'b1) $display("FAIL pt_overrun got=%b exp=1", overrun0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_truncation();
        test_max();
        test_handshake();
        test_backpressure();
        test_reset_mid();
        test_passthrough();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
